// File: rtl/large_mult_seq_stream.sv
// Sequential digit-serial multiplier with valid/ready handshakes on both sides.
// Consumes DIGIT_WIDTH multiplier bits per cycle, optionally on two's-complement operands.
module large_mult_seq_stream #(
  parameter int IN0_WIDTH   = 64,
  parameter int IN1_WIDTH   = 64,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [IN0_WIDTH-1:0]           in0,
  input  logic [IN1_WIDTH-1:0]           in1,
  input  logic                           signed_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IN0_WIDTH+IN1_WIDTH-1:0] outp,
  output logic                           busy
);

  localparam int P  = IN0_WIDTH + IN1_WIDTH;
  localparam int N  = IN1_WIDTH / DIGIT_WIDTH;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  if (IN1_WIDTH % DIGIT_WIDTH != 0) begin : g_param_check
    $error("large_mult_seq_stream: IN1_WIDTH must be a multiple of DIGIT_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state, state_next;
  logic [P-1:0]           mag0_sh;
  logic [IN1_WIDTH-1:0]   mag1;
  logic                   sign_r;
  logic [P-1:0]           acc;
  logic [CW-1:0]          cnt;

  logic                   neg0, neg1;
  logic [IN0_WIDTH-1:0]   abs0;
  logic [IN1_WIDTH-1:0]   abs1;
  logic [P-1:0]           partial;

  // Magnitudes are taken as unsigned, so the negated minimum value is exact.
  assign neg0    = signed_mode & in0[IN0_WIDTH-1];
  assign neg1    = signed_mode & in1[IN1_WIDTH-1];
  assign abs0    = neg0 ? -in0 : in0;
  assign abs1    = neg1 ? -in1 : in1;
  // The multiplicand is pre-shifted each cycle, which equals shifting by cnt*DIGIT_WIDTH.
  assign partial = mag0_sh * P'(mag1[DIGIT_WIDTH-1:0]);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid)             state_next = BUSY;
      BUSY: if (cnt == LAST_DIGIT)    state_next = DONE;
      DONE: if (out_ready)            state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  // NOTE: datapath registers are cleared on reset as well, so an aborted
  // operation leaves no residue in the accumulator or latched operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag0_sh <= '0;
      mag1    <= '0;
      sign_r  <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          mag0_sh <= P'(abs0);
          mag1    <= abs1;
          sign_r  <= neg0 ^ neg1;
          acc     <= '0;
          cnt     <= '0;
        end
        BUSY: begin
          acc     <= acc + partial;
          mag0_sh <= mag0_sh << DIGIT_WIDTH;
          mag1    <= mag1 >> DIGIT_WIDTH;
          cnt     <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign outp      = (state == DONE) ? (sign_r ? -acc : acc) : '0;

endmodule

// File: tb/tb_large_mult_seq_stream.sv
// Self-checking bench for large_mult_seq_stream at default parameters:
// directed corner cases plus randomized operands against an arithmetic reference.
module tb_large_mult_seq_stream;

  localparam int N_DIG = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in0;
  logic [63:0]  in1;
  logic         signed_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] outp;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  large_mult_seq_stream dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in0         (in0),
    .in1         (in1),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .outp        (outp),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference product straight from integer arithmetic at full width.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic sm);
    logic signed [127:0] sa;
    logic signed [127:0] sb;
    if (sm) begin
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      return sa * sb;
    end
    return {64'd0, a} * {64'd0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; stall = cycles out_ready stays low once out_valid is seen.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic sm,
                       input int stall, output int lat, output logic [127:0] res);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("ready_before_op", in_ready, 1'b1);
    in0 = a; in1 = b; signed_mode = sm; in_valid = 1'b1;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    in0 = {$urandom, $urandom};
    in1 = {$urandom, $urandom};
    signed_mode = ~sm;
    check("busy_after_accept", {in_ready, busy, outp == 128'd0}, 3'b011);
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    res = outp;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_hold", {out_valid, outp}, {1'b1, res});
    end
    out_ready = 1'b1;
    tick();
  endtask

  logic [127:0] res, held, exp;
  logic [63:0]  a_arr [10];
  logic [63:0]  b_arr [10];
  logic         m_arr [10];
  logic [127:0] exp_q [$];
  int lat, cyc, last, got, idx, quiet;
  logic acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; signed_mode = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_state", {in_ready, out_valid, busy, outp}, {3'b100, 128'd0});

    // Unsigned 3 x 5 with immediate consumer.
    do_op(64'd3, 64'd5, 1'b0, 0, lat, res);
    check("lat_3x5", lat, N_DIG + 1);
    check("prod_3x5", res, 128'd15);
    check("ready_after_retire", {in_ready, out_valid, busy}, 3'b100);

    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 0, lat, res);
    check("signed_m1x1", res, {128{1'b1}});
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 0, lat, res);
    check("signed_min_sq", res, 128'd1 << 126);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, lat, res);
    check("unsigned_max_sq", res, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    do_op(64'd0, 64'd0, 1'b0, 0, lat, res);
    check("lat_zero", lat, N_DIG + 1);
    check("prod_zero", res, 128'd0);

    // Consumer stall: 5 cycles held in DONE with in_valid pulses, retire on the 6th.
    in0 = 64'h0123_4567_89AB_CDEF; in1 = 64'hFEDC_BA98_7654_3210; signed_mode = 1'b1;
    exp = ref_mul(in0, in1, 1'b1);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    check("lat_stall", lat, N_DIG + 1);
    held = outp;
    check("prod_stall", held, exp);
    for (int i = 0; i < 5; i++) begin
      check("stall_stable", {out_valid, in_ready, outp}, {2'b10, held});
      in_valid = ~in_valid;
      in0 = {$urandom, $urandom};
      tick();
    end
    in_valid = 1'b0;
    check("stall_6th", {out_valid, in_ready, outp}, {2'b10, exp});
    out_ready = 1'b1;
    tick();
    check("stall_retired", {in_ready, out_valid, busy, outp}, {3'b100, 128'd0});

    // Reset on the 8th BUSY cycle aborts without an output pulse.
    in0 = 64'd1234; in1 = 64'd5678; signed_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("busy_8th", {busy, in_ready}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", {in_ready, busy, out_valid, outp}, {3'b100, 128'd0});
    quiet = 0;
    for (int i = 0; i < N_DIG + 4; i++) begin
      if (out_valid) quiet++;
      tick();
    end
    check("abort_no_pulse", quiet, 0);
    do_op(64'd7, 64'd9, 1'b0, 0, lat, res);
    check("lat_7x9", lat, N_DIG + 1);
    check("prod_7x9", res, 128'd63);

    // Random operations with random consumer stalls.
    for (int k = 0; k < 8; k++) begin
      logic [63:0] ra, rb;
      logic rm;
      int st;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rm = 1'($urandom_range(0, 1));
      st = int'($urandom_range(0, 3));
      do_op(ra, rb, rm, st, lat, res);
      check("rand_lat", lat, N_DIG + 1);
      check("rand_prod", res, ref_mul(ra, rb, rm));
    end

    // Back-to-back stream with in_valid held high.
    a_arr[0] = 64'h8000_0000_0000_0000; b_arr[0] = 64'h7FFF_FFFF_FFFF_FFFF; m_arr[0] = 1'b1;
    a_arr[1] = 64'hFFFF_FFFF_FFFF_FFFF; b_arr[1] = 64'h8000_0000_0000_0000; m_arr[1] = 1'b0;
    for (int k = 2; k < 10; k++) begin
      a_arr[k] = {$urandom, $urandom};
      b_arr[k] = {$urandom, $urandom};
      m_arr[k] = 1'($urandom_range(0, 1));
    end
    idx = 0; got = 0; cyc = 0; last = 0;
    in0 = a_arr[0]; in1 = b_arr[0]; signed_mode = m_arr[0];
    in_valid = 1'b1; out_ready = 1'b1;
    while (got < 10 && cyc < 1000) begin
      if (out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hX;
        check("stream_prod", outp, exp);
        if (got > 0) check("stream_gap", cyc - last, N_DIG + 2);
        last = cyc;
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(ref_mul(a_arr[idx], b_arr[idx], m_arr[idx]));
      tick();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 10) begin
          in0 = a_arr[idx]; in1 = b_arr[idx]; signed_mode = m_arr[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("stream_count", got, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/large_mult_seq_stream.md
LARGE_MULT_SEQ_STREAM -- requirements
Module: large_mult_seq_stream

Interface
REQ-001 The block SHALL have parameter IN0_WIDTH, default 64, meaning the width of multiplicand in0.
REQ-002 The block SHALL have parameter IN1_WIDTH, default 64, meaning the width of multiplier in1.
REQ-003 The block SHALL have parameter DIGIT_WIDTH, default 4, meaning the multiplier bits consumed per BUSY cycle; IN1_WIDTH SHALL be an integer multiple of it.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operands and mode present.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 in0  input  IN0_WIDTH  multiplicand.
REQ-009 in1  input  IN1_WIDTH  multiplier.
REQ-010 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 out_valid  output  1  outp holds a completed product.
REQ-012 out_ready  input  1  consumer accepts outp.
REQ-013 outp  output  IN0_WIDTH+IN1_WIDTH  product.
REQ-014 busy  output  1  high in BUSY or DONE state.

Function
REQ-015 The block SHALL implement FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 An accept SHALL occur on an edge where in_valid=1 and in_ready=1; in0, in1 and signed_mode SHALL be latched then, and the FSM SHALL move to BUSY with digit counter 0 and accumulator 0.
REQ-017 In signed mode the block SHALL latch operand magnitudes and a result sign equal to sign(in0) XOR sign(in1); in unsigned mode the magnitudes are the operands and the sign is 0.
REQ-018 Each BUSY cycle SHALL add (mag0 * low DIGIT_WIDTH bits of the shifted mag1) shifted left by counter*DIGIT_WIDTH into a full-width accumulator, shift mag1 right by DIGIT_WIDTH and increment the counter.
REQ-019 After exactly N = IN1_WIDTH/DIGIT_WIDTH BUSY cycles the FSM SHALL enter DONE; no early termination for zero or small operands.
REQ-020 out_valid SHALL first be 1 exactly N+1 cycles after the accept edge (N=16 at defaults), and only in DONE.
REQ-021 In DONE, outp SHALL equal the accumulator, two's-complement negated if the result sign is 1, and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 On an edge with out_valid=1 and out_ready=1 the FSM SHALL return to IDLE; in_ready SHALL rise the following cycle (no same-cycle accept and retire).
REQ-023 Input changes while not in IDLE SHALL be ignored.
REQ-024 Signed minimum operands (-2^(W-1)) SHALL be handled exactly; the product of the two minima SHALL be +2^(IN0_WIDTH+IN1_WIDTH-2).
REQ-025 outp SHALL be 0 whenever out_valid=0.
REQ-026 A non-multiple IN1_WIDTH/DIGIT_WIDTH parameter setting SHALL raise a simulation-time error.

Reset
REQ-027 While rst=1 the FSM SHALL go to IDLE, and the accumulator, counter and latched operands SHALL clear to 0.
REQ-028 The cycle after rst deasserts, in_ready SHALL be 1, and out_valid, busy and outp SHALL be 0.
REQ-029 rst during BUSY or DONE SHALL abort the operation with no out_valid pulse for it.
REQ-030 rst SHALL take priority over a simultaneous accept or retire.

Verification
REQ-031 Unsigned 3 x 5, out_ready=1 -> out_valid high 17 cycles after accept, outp=15, in_ready returns the next cycle.
REQ-032 Signed -1 x 1 -> outp = all ones (128 bits); signed 0x8000_0000_0000_0000 squared -> outp = 2^126.
REQ-033 Unsigned (2^64-1) x (2^64-1) -> outp = 0xFFFFFFFFFFFFFFFE_0000000000000001.
REQ-034 out_ready held low 5 cycles in DONE -> outp and out_valid stable, in_ready=0, in_valid pulses ignored; retire on the 6th cycle.
REQ-035 rst asserted on the 8th BUSY cycle -> next cycle in_ready=1, busy=0, out_valid=0; a fresh 7 x 9 then yields 63.
REQ-036 Back-to-back in_valid held high with 10 operand pairs -> 10 products in order, each N+2 cycles apart.
